bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the four-digit seven-segment multiplexer. It turns a binary count into the ones/tens/hundreds/thousands nibbles that the multiplexer decodes. Its outputs are registered and held stable between conversions so the display never shows partial results. Values above 9999 produce all-4'hF digits, which the display renders as dashes.

---
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to four-digit BCD converter
module bin2bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sr;
  logic [15:0]        acc;
  logic [15:0]        acc_adj;
  logic [15+WIDTH:0]  shift_v;
  logic [3:0]         cnt;
  logic               load_pend;
  logic               dash_pend;
  logic               in_range;
  logic               accept_ok;
  logic               accept_dash;

  assign in_range    = ({{(32-WIDTH){1'b0}}, bin} <= 32'd9999);
  assign accept_ok   = (state == IDLE) && start && in_range;
  assign accept_dash = (state == IDLE) && start && !in_range;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    shift_v = {acc_adj, sr} << 1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (accept_ok) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digits and ovf are only written on the done edge so the display never sees partial results.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      load_pend <= 1'b0;
      dash_pend <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      ones      <= '0;
      tens      <= '0;
      hundreds  <= '0;
      thousands <= '0;
    end else begin
      done      <= 1'b0;
      load_pend <= 1'b0;
      dash_pend <= accept_dash;
      if (accept_ok) begin
        sr  <= bin;
        acc <= '0;
        cnt <= 4'(WIDTH);
      end else if (state == SHIFT) begin
        acc       <= shift_v[15+WIDTH:WIDTH];
        sr        <= shift_v[WIDTH-1:0];
        cnt       <= cnt - 4'd1;
        load_pend <= (cnt == 4'd1);
      end
      if (load_pend) begin
        ones      <= acc[3:0];
        tens      <= acc[7:4];
        hundreds  <= acc[11:8];
        thousands <= acc[15:12];
        ovf       <= 1'b0;
        done      <= 1'b1;
      end else if (dash_pend) begin
        ones      <= 4'hF;
        tens      <= 4'hF;
        hundreds  <= 4'hF;
        thousands <= 4'hF;
        ovf       <= 1'b1;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] bin = '0;
  logic         busy, done, ovf;
  logic [3:0]   ones, tens, hundreds, thousands;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          value;
    logic [15:0] exp_digits;
    logic        exp_ovf;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  bin2bcd_seq #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .bin(bin),
    .busy(busy), .done(done), .ovf(ovf),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {thousands, hundreds, tens, ones};
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'hFFFF;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Starts one conversion and observes it until done (bounded).
  task automatic run_one(input int v, output int lat, output logic [15:0] dig,
                         output logic ov, output int busy_cnt, output int held_bad,
                         output logic done_after);
    logic [15:0] prev;
    logic        got;
    prev     = digits();
    held_bad = 0;
    bin      = W'(v);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = int'(busy);
    lat      = 0;
    got      = 1'b0;
    while (lat < 20 && !got) begin
      tick();
      lat++;
      busy_cnt += int'(busy);
      if (done) got = 1'b1;
      else if (digits() !== prev) held_bad++;
    end
    dig = digits();
    ov  = ovf;
    tick();
    done_after = done;
    if (digits() !== dig) held_bad++;
  endtask

  int          lat, busy_cnt, held_bad;
  logic [15:0] dig;
  logic        ov, done_after;
  vec_t        vecs[8];
  int          done_k[$];
  logic [15:0] done_d[$];
  int          n, rv;

  initial begin
    vecs[0] = '{0,     16'h0000, 1'b0, 15, 14};
    vecs[1] = '{9999,  16'h9999, 1'b0, 15, 14};
    vecs[2] = '{1234,  16'h1234, 1'b0, 15, 14};
    vecs[3] = '{10000, 16'hFFFF, 1'b1, 1,  0};
    vecs[4] = '{16383, 16'hFFFF, 1'b1, 1,  0};
    vecs[5] = '{42,    16'h0042, 1'b0, 15, 14};
    vecs[6] = '{8765,  16'h8765, 1'b0, 15, 14};
    vecs[7] = '{1,     16'h0001, 1'b0, 15, 14};

    #12;
    chk("reset_digits", 32'(digits()), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_ovf", 32'(ovf), 32'h0);
    clr = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].value, lat, dig, ov, busy_cnt, held_bad, done_after);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_digits", i), 32'(dig), 32'(vecs[i].exp_digits));
      chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_held", i), 32'(held_bad), 32'h0);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done_after), 32'h0);
    end

    for (int i = 0; i < 20; i++) begin
      rv = int'($urandom_range(16383, 0));
      run_one(rv, lat, dig, ov, busy_cnt, held_bad, done_after);
      chk($sformatf("rnd%0d_latency v=%0d", i, rv), 32'(lat), (rv > 9999) ? 32'd1 : 32'd15);
      chk($sformatf("rnd%0d_digits v=%0d", i, rv), 32'(dig), 32'(ref_bcd(rv)));
      chk($sformatf("rnd%0d_ovf v=%0d", i, rv), 32'(ov), (rv > 9999) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d_held v=%0d", i, rv), 32'(held_bad), 32'h0);
    end

    // Held start: bin changes mid-flight; each done edge re-accepts.
    bin   = W'(7);
    start = 1'b1;
    tick();
    for (int k = 1; k <= 47; k++) begin
      if (k == 5) bin = W'(5);
      tick();
      if (done) begin
        done_k.push_back(k);
        done_d.push_back(digits());
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_k.size()), 32'd3);
    if (done_k.size() == 3) begin
      chk("held_done1_edge", 32'(done_k[0]), 32'd15);
      chk("held_done2_edge", 32'(done_k[1]), 32'd30);
      chk("held_done3_edge", 32'(done_k[2]), 32'd45);
      chk("held_result1", 32'(done_d[0]), 32'h0007);
      chk("held_result2", 32'(done_d[1]), 32'h0005);
    end
    n = 0;
    while (n < 20 && !done) begin tick(); n++; end
    chk("held_drain", 32'(n < 20), 32'd1);
    tick();

    // Start pulse during busy is ignored.
    bin   = W'(300);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin   = W'(99);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 5;
    while (n < 25 && !done) begin tick(); n++; end
    chk("ignore_latency", 32'(n), 32'd15);
    chk("ignore_digits", 32'(digits()), 32'h0300);
    n = 0;
    repeat (20) begin tick(); n += int'(done); end
    chk("ignore_no_extra_done", 32'(n), 32'd0);

    // Asynchronous reset mid-conversion.
    run_one(4321, lat, dig, ov, busy_cnt, held_bad, done_after);
    chk("pre_reset_digits", 32'(digits()), 32'h4321);
    bin   = W'(1111);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 clr = 1'b0;
    #1;
    chk("async_reset_digits", 32'(digits()), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    chk("async_reset_done", 32'(done), 32'h0);
    chk("async_reset_ovf", 32'(ovf), 32'h0);
    tick();
    #2 clr = 1'b1;
    bin   = W'(42);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 20 && !done) begin tick(); n++; end
    chk("post_reset_latency", 32'(n), 32'd15);
    chk("post_reset_digits", 32'(digits()), 32'h0042);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
